stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Two-button front-end controller that sequences the stopwatch timer.
//   - Turns raw button levels into single-cycle tmr_start/tmr_stop/tmr_reset commands.
//   - Owns the display value and a freeze-on-lap (split) function.
//   - Computes the per-lap elapsed time, including across timer wrap at MAX.
//   - Sits between the panel button synchronisers and the timer datapath.
// PARAMETERS
//   DATA_WIDTH   16  width of tmr_count, disp_count, lap_delta
//   MAX          99  terminal count of the controlled timer (timer goes MAX -> 0)
//   LAP_WIDTH    4   width of lap_num; lap_num wraps modulo 2^LAP_WIDTH
//   HOLD_CYCLES  8   cycles the display stays frozen after a lap capture (>=1)
// PORTS
//   clk         in   1           clock
//   reset       in   1           synchronous active-high reset
//   btn_ss      in   1           start/stop button level (already synchronised)
//   btn_lr      in   1           lap/reset button level (already synchronised)
//   tmr_count   in   DATA_WIDTH  live count from the timer
//   tmr_start   out  1           one-cycle start command to the timer
//   tmr_stop    out  1           one-cycle stop command to the timer
//   tmr_reset   out  1           one-cycle reset command to the timer
//   disp_count  out  DATA_WIDTH  value to display (registered)
//   lap_valid   out  1           one-cycle strobe: lap captured
//   lap_num     out  LAP_WIDTH   number of laps captured since IDLE
//   lap_delta   out  DATA_WIDTH  elapsed counts since the previous lap, valid with lap_valid
//   state_o     out  2           IDLE=0, RUN=1, SPLIT=2, PAUSED=3
// BEHAVIOUR
//   Reset:
//     - state=IDLE; all strobes 0; disp_count, lap_num, lap_delta, prev_lap and hold counter = 0.
//     - Button history regs reset to 1, so a button held through reset is not a press.
//   Press detection:
//     - press = btn & ~btn_q, evaluated at each edge.
//     - A button held high yields exactly one press.
//     - ss and lr pressed at the same edge: ss acts, lr is discarded.
//   Command latency:
//     - Press sampled at edge k -> command strobe high for exactly cycle k..k+1.
//     - All outputs are registered.
//   Transitions on ss press:
//     - IDLE -> RUN, tmr_start.
//     - RUN -> PAUSED, tmr_stop.
//     - SPLIT -> PAUSED, tmr_stop; display unfreezes.
//     - PAUSED -> RUN, tmr_start.
//   Transitions on lr press:
//     - IDLE: stays IDLE, tmr_reset.
//     - RUN -> SPLIT:
//       - Capture tmr_count sampled at the press edge into disp_count and prev_lap.
//       - Pulse lap_valid; lap_num++.
//       - Load hold counter with HOLD_CYCLES.
//     - SPLIT: stays SPLIT; new capture as above and hold counter reloaded.
//     - PAUSED -> IDLE:
//       - tmr_reset pulse.
//       - lap_num, prev_lap and disp_count go to 0.
//   Split hold:
//     - Capture at edge k: disp_count frozen for cycles k..k+HOLD_CYCLES.
//     - At edge k+HOLD_CYCLES, state returns to RUN and disp_count <= tmr_count.
//   Display in RUN/PAUSED: disp_count <= tmr_count every edge (1-cycle lag).
//   Display in IDLE: disp_count = 0.
//   lap_delta:
//     - If cur >= prev_lap: cur - prev_lap.
//     - Otherwise: cur + (MAX+1) - prev_lap; compute at DATA_WIDTH+1 bits.
//     - prev_lap is kept across PAUSED and cleared only on entering IDLE.
//     - lap_delta holds its value between laps.
//   lap_num wraps from 2^LAP_WIDTH-1 to 0; lap_valid still pulses.
//   Reset mid-operation (any state, including an active hold):
//     - Returns to reset values at the next edge.
//     - No command strobe is issued for that edge.
// TESTING
//   1. Reset, btn_ss rises at edge 10 and is held 20 cycles
//      -> tmr_start=1 one cycle only; state_o=1.
//   2. RUN, btn_lr rises with tmr_count=37
//      -> lap_valid one cycle, lap_num=1, lap_delta=37, disp_count=37 for 8 cycles, then tracks tmr_count.
//   3. Wrap, MAX=99: prev lap at 90, next lap at tmr_count=5 -> lap_delta=15, lap_num=2.
//   4. RUN, btn_ss and btn_lr rise on the same edge
//      -> tmr_stop only, no lap_valid, state_o=3.
//   5. PAUSED, btn_lr rises -> tmr_reset one cycle, lap_num=0, disp_count=0, state_o=0.
//      Then btn_ss rises -> tmr_start.
//   6. Reset asserted at hold cycle 3 of SPLIT
//      -> next cycle state_o=0, all outputs 0, no strobes; a held button gives no press after release.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch front end: turns button edges into timer commands,
// owns the display, freezes it on lap capture and reports per-lap elapsed time.
module stopwatch_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX         = 99,
    parameter int LAP_WIDTH   = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_ss,
    input  logic                  btn_lr,
    input  logic [DATA_WIDTH-1:0] tmr_count,
    output logic                  tmr_start,
    output logic                  tmr_stop,
    output logic                  tmr_reset,
    output logic [DATA_WIDTH-1:0] disp_count,
    output logic                  lap_valid,
    output logic [LAP_WIDTH-1:0]  lap_num,
    output logic [DATA_WIDTH-1:0] lap_delta,
    output logic [1:0]            state_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] MODULUS = DATA_WIDTH'(MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SPLIT  = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    btn_ss_q, btn_lr_q;
    logic                    start_q, start_d;
    logic                    stop_q, stop_d;
    logic                    treset_q, treset_d;
    logic                    lap_valid_q, lap_valid_d;
    logic [DATA_WIDTH-1:0]   disp_q, disp_d;
    logic [DATA_WIDTH-1:0]   prev_lap_q, prev_lap_d;
    logic [DATA_WIDTH-1:0]   lap_delta_q, lap_delta_d;
    logic [LAP_WIDTH-1:0]    lap_num_q, lap_num_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    ss_press, lr_press;

    // Wrapped branch is modular in DATA_WIDTH bits; the true result is < MAX+1,
    // so any carry out of cur + (MAX+1) cancels against the subtraction.
    function automatic logic [DATA_WIDTH-1:0] lap_elapsed(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] prev
    );
        if (cur >= prev) begin
            return cur - prev;
        end
        return cur + (MODULUS - prev);
    endfunction

    always_comb begin
        ss_press    = btn_ss & ~btn_ss_q;
        lr_press    = btn_lr & ~btn_lr_q & ~ss_press;
        state_d     = state_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        treset_d    = 1'b0;
        lap_valid_d = 1'b0;
        disp_d      = disp_q;
        prev_lap_d  = prev_lap_q;
        lap_delta_d = lap_delta_q;
        lap_num_d   = lap_num_q;
        hold_d      = hold_q;

        case (state_q)
            IDLE: begin
                disp_d = '0;
                if (ss_press) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    disp_d  = tmr_count;
                end else if (lr_press) begin
                    treset_d = 1'b1;
                end
            end
            RUN, SPLIT: begin
                if (ss_press) begin
                    state_d = PAUSED;
                    stop_d  = 1'b1;
                    disp_d  = tmr_count;
                end else if (lr_press) begin
                    state_d     = SPLIT;
                    lap_valid_d = 1'b1;
                    disp_d      = tmr_count;
                    prev_lap_d  = tmr_count;
                    lap_delta_d = lap_elapsed(tmr_count, prev_lap_q);
                    lap_num_d   = lap_num_q + 1'b1;
                    hold_d      = HOLD_W'(HOLD_CYCLES);
                end else if (state_q == RUN) begin
                    disp_d = tmr_count;
                end else if (hold_q == HOLD_W'(1)) begin
                    state_d = RUN;
                    disp_d  = tmr_count;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            PAUSED: begin
                disp_d = tmr_count;
                if (ss_press) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else if (lr_press) begin
                    state_d    = IDLE;
                    treset_d   = 1'b1;
                    lap_num_d  = '0;
                    prev_lap_d = '0;
                    disp_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // History regs reset high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            btn_ss_q    <= 1'b1;
            btn_lr_q    <= 1'b1;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            treset_q    <= 1'b0;
            lap_valid_q <= 1'b0;
            disp_q      <= '0;
            prev_lap_q  <= '0;
            lap_delta_q <= '0;
            lap_num_q   <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            btn_ss_q    <= btn_ss;
            btn_lr_q    <= btn_lr;
            start_q     <= start_d;
            stop_q      <= stop_d;
            treset_q    <= treset_d;
            lap_valid_q <= lap_valid_d;
            disp_q      <= disp_d;
            prev_lap_q  <= prev_lap_d;
            lap_delta_q <= lap_delta_d;
            lap_num_q   <= lap_num_d;
            hold_q      <= hold_d;
        end
    end

    assign tmr_start  = start_q;
    assign tmr_stop   = stop_q;
    assign tmr_reset  = treset_q;
    assign lap_valid  = lap_valid_q;
    assign disp_count = disp_q;
    assign lap_num    = lap_num_q;
    assign lap_delta  = lap_delta_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios with literal expectations, then
// randomized button/reset traffic against an event-level model of the stopwatch.
module tb_stopwatch_ctrl;

    localparam int DW    = 16;
    localparam int MAXV  = 99;
    localparam int LAPW  = 4;
    localparam int HOLD  = 8;
    localparam int S_IDLE = 0, S_RUN = 1, S_SPLIT = 2, S_PAUSED = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_ss = 1'b0;
    logic          btn_lr = 1'b0;
    logic [DW-1:0] tmr_count = '0;
    logic          tmr_start, tmr_stop, tmr_reset, lap_valid;
    logic [DW-1:0] disp_count, lap_delta;
    logic [LAPW-1:0] lap_num;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    // Model of the stopwatch as the user sees it
    int m_mode, m_laps, m_prev, m_delta, m_disp, m_freeze;
    bit m_ss_last, m_lr_last;
    bit e_start, e_stop, e_rst, e_lap;

    stopwatch_ctrl #(
        .DATA_WIDTH(DW), .MAX(MAXV), .LAP_WIDTH(LAPW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .tmr_count(tmr_count), .tmr_start(tmr_start), .tmr_stop(tmr_stop),
        .tmr_reset(tmr_reset), .disp_count(disp_count), .lap_valid(lap_valid),
        .lap_num(lap_num), .lap_delta(lap_delta), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit ss, input bit lr, input bit rst, input int cnt);
        bit ssp, lrp;
        e_start = 0; e_stop = 0; e_rst = 0; e_lap = 0;
        if (rst) begin
            m_mode = S_IDLE; m_ss_last = 1; m_lr_last = 1; m_laps = 0;
            m_prev = 0; m_delta = 0; m_disp = 0; m_freeze = 0;
            return;
        end
        ssp = ss && !m_ss_last;
        lrp = lr && !m_lr_last && !ssp;
        m_ss_last = ss;
        m_lr_last = lr;
        if (ssp) begin
            if (m_mode == S_IDLE || m_mode == S_PAUSED) begin
                m_mode = S_RUN; e_start = 1;
            end else begin
                m_mode = S_PAUSED; e_stop = 1;
            end
        end else if (lrp) begin
            if (m_mode == S_IDLE) begin
                e_rst = 1;
            end else if (m_mode == S_PAUSED) begin
                m_mode = S_IDLE; e_rst = 1; m_laps = 0; m_prev = 0;
            end else begin
                e_lap    = 1;
                m_delta  = (cnt - m_prev + MAXV + 1) % (MAXV + 1);
                m_prev   = cnt;
                m_laps   = (m_laps + 1) % (1 << LAPW);
                m_freeze = HOLD;
                m_mode   = S_SPLIT;
            end
        end else if (m_mode == S_SPLIT) begin
            m_freeze--;
            if (m_freeze == 0) m_mode = S_RUN;
        end
        if (m_mode == S_IDLE) m_disp = 0;
        else if (m_mode != S_SPLIT || e_lap) m_disp = cnt;
    endtask

    task automatic compare_model();
        chk("state", state_o, m_mode);
        chk("tmr_start", tmr_start, e_start);
        chk("tmr_stop", tmr_stop, e_stop);
        chk("tmr_reset", tmr_reset, e_rst);
        chk("lap_valid", lap_valid, e_lap);
        chk("lap_num", lap_num, m_laps);
        chk("lap_delta", lap_delta, m_delta);
        chk("disp_count", disp_count, m_disp);
    endtask

    // One clock: drive, let the edge happen, advance the model, compare mid-cycle.
    task automatic step(input bit ss, input bit lr, input bit rst, input int cnt);
        btn_ss    = ss;
        btn_lr    = lr;
        reset     = rst;
        tmr_count = DW'(cnt);
        @(posedge clk);
        model_edge(ss, lr, rst, cnt);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        bit ss, lr;
        // Reset and start press held for 20 cycles
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t1_reset_state", state_o, 0);
        chk("t1_reset_disp", disp_count, 0);
        chk("t1_reset_strobes", {tmr_start, tmr_stop, tmr_reset, lap_valid}, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("t1_start", tmr_start, 1);
        chk("t1_state_run", state_o, 1);
        step(1, 0, 0, 1);
        chk("t1_start_once", tmr_start, 0);
        for (int i = 0; i < 18; i++) step(1, 0, 0, 2 + i);

        // Lap at 37, frozen for HOLD cycles
        step(0, 0, 0, 20);
        step(0, 1, 0, 37);
        chk("t2_lap_valid", lap_valid, 1);
        chk("t2_lap_num", lap_num, 1);
        chk("t2_lap_delta", lap_delta, 37);
        chk("t2_disp", disp_count, 37);
        for (int i = 1; i < HOLD; i++) begin
            step(0, 1, 0, 37 + i);
            chk("t2_disp_frozen", disp_count, 37);
        end
        step(0, 1, 0, 50);
        chk("t2_disp_tracks", disp_count, 50);
        chk("t2_back_to_run", state_o, 1);

        // Laps at 90 then 5 across the wrap
        step(0, 0, 0, 60);
        step(0, 1, 0, 90);
        chk("t3_delta_90", lap_delta, 53);
        step(0, 0, 0, 91);
        step(0, 1, 0, 5);
        chk("t3_wrap_delta", lap_delta, 15);
        chk("t3_lap_num", lap_num, 3);

        // Simultaneous press: start/stop wins
        for (int i = 0; i < HOLD; i++) step(0, 0, 0, 10 + i);
        step(1, 1, 0, 30);
        chk("t4_stop", tmr_stop, 1);
        chk("t4_no_lap", lap_valid, 0);
        chk("t4_paused", state_o, 3);

        // Reset from PAUSED, then restart
        step(0, 0, 0, 31);
        step(0, 1, 0, 32);
        chk("t5_tmr_reset", tmr_reset, 1);
        chk("t5_lap_num", lap_num, 0);
        chk("t5_disp", disp_count, 0);
        chk("t5_idle", state_o, 0);
        step(0, 0, 0, 33);
        chk("t5_reset_once", tmr_reset, 0);
        step(1, 0, 0, 34);
        chk("t5_restart", tmr_start, 1);

        // Reset during hold with buttons held
        step(0, 0, 0, 35);
        step(0, 1, 0, 40);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 41 + i);
        step(1, 1, 1, 44);
        chk("t6_state", state_o, 0);
        chk("t6_outputs", {disp_count, lap_delta, 12'(lap_num)}, 0);
        chk("t6_strobes", {tmr_start, tmr_stop, tmr_reset, lap_valid}, 0);
        step(1, 1, 0, 45);
        chk("t6_held_no_press", {tmr_start, tmr_reset, lap_valid, 2'(state_o)}, 0);
        step(0, 0, 0, 46);
        chk("t6_release_idle", state_o, 0);
        step(1, 0, 0, 47);
        chk("t6_new_press", tmr_start, 1);

        // lap_num wrap after 2^LAP_WIDTH laps
        step(0, 0, 0, 48);
        for (int i = 1; i <= (1 << LAPW); i++) begin
            step(0, 1, 0, (i * 7) % (MAXV + 1));
            if (i == (1 << LAPW) - 1) chk("wrap_lap_15", lap_num, 15);
            step(0, 0, 0, 0);
        end
        chk("wrap_lap_0", lap_num, 0);

        // Randomized traffic
        ss = 0;
        lr = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 23) == 0) ss = ~ss;
            if ($urandom_range(0, 15) == 0) lr = ~lr;
            step(ss, lr, $urandom_range(0, 299) == 0, $urandom_range(0, MAXV));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
